// File: rtl/lsu_pkg.sv
// Shared types and lane constants for the lsu_rmw load/store unit.
// The optional misaligned-access trap is controlled by LSU_MISALIGN_TRAP_EN
// (see lsu_rmw.sv); the helpers here serve both builds.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  // Lane geometry of a little-endian 32-bit word.
  localparam int unsigned BYTE_BITS   = 8;
  localparam int unsigned HALF_BITS   = 16;
  localparam int unsigned HALF_HI_LSB = 16;

  function automatic logic is_misaligned(size_e size, logic [1:0] lo);
    return ((size == SZ_H) && lo[0]) || ((size == SZ_W) && (lo != 2'b00));
  endfunction

  // Forces the low address bits onto the natural boundary of the access.
  function automatic logic [1:0] align_lo(size_e size, logic [1:0] lo);
    case (size)
      SZ_H:    return {lo[1], 1'b0};
      SZ_W:    return 2'b00;
      default: return lo;
    endcase
  endfunction

endpackage

// File: rtl/lsu_rmw_if.sv
// Core-side request/response bus of the load/store unit.
// master = memory stage of the core, slave = lsu_rmw.
interface lsu_rmw_if #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends a byte/half for loads and
// merges store data into a fetched word for read-modify-write stores.
// addr_lo is expected to be already aligned to the access size.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  size_e       size,
  input  logic        is_unsigned,
  input  logic [31:0] mem_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [4:0]  byte_lsb;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_lsb = {addr_lo, 3'b000};

  // Select the addressed lane, then extend (load) or overwrite it (store).
  always_comb begin
    byte_v     = mem_word[byte_lsb +: BYTE_BITS];
    half_v     = addr_lo[1] ? mem_word[HALF_HI_LSB +: HALF_BITS] : mem_word[0 +: HALF_BITS];
    load_data  = mem_word;
    merge_data = store_data;
    case (size)
      SZ_B: begin
        load_data  = {{24{!is_unsigned && byte_v[7]}}, byte_v};
        merge_data = mem_word;
        merge_data[byte_lsb +: BYTE_BITS] = store_data[7:0];
      end
      SZ_H: begin
        load_data  = {{16{!is_unsigned && half_v[15]}}, half_v};
        merge_data = mem_word;
        if (addr_lo[1]) merge_data[HALF_HI_LSB +: HALF_BITS] = store_data[15:0];
        else            merge_data[0 +: HALF_BITS]           = store_data[15:0];
      end
      default: begin
        load_data  = mem_word;
        merge_data = store_data;
      end
    endcase
  end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit in front of a word-only memory with a 1-cycle registered
// read. Adds byte/half loads with extension and sub-word stores done as
// read-modify-write. One request in flight at a time.
// Build option: LSU_MISALIGN_TRAP_EN -- when defined, misaligned half/word
// accesses return rsp_err; otherwise the low address bits are forced aligned.
//
// state | meaning
// IDLE  | ready for a request; response pulse of the previous one may show here
// READ  | word address on the memory port, read issued
// DATA  | read word available: extract for loads, merge for sub-word stores
// WRITE | mem_we asserted for this single cycle
// ERR   | illegal request answered, no memory access
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              reset,
  lsu_rmw_if.slave          bus,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
);

  state_e            state_q, state_d;
  logic              accept;
  logic              illegal_req;
  size_e             req_size_e;

  logic [1:0]        addr_lo_q;
  size_e             size_q;
  logic              we_q;
  logic              uns_q;
  logic [XLEN-1:0]   wdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [XLEN-1:0]   mem_wdata_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [XLEN-1:0]   rsp_rdata_q;

  logic [XLEN-1:0]   load_data;
  logic [XLEN-1:0]   merge_data;

  assign req_size_e = size_e'(bus.req_size);

  // Classify the incoming request as illegal for this build.
  always_comb begin
    illegal_req = (req_size_e == SZ_X);
`ifdef LSU_MISALIGN_TRAP_EN
    illegal_req = illegal_req || is_misaligned(req_size_e, bus.req_addr[1:0]);
`endif
  end

  // Next-state logic; acceptance only happens from IDLE.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (illegal_req)                             state_d = ST_ERR;
          else if (bus.req_we && (req_size_e == SZ_W)) state_d = ST_WRITE;
          else                                         state_d = ST_READ;
        end
      end
      ST_READ:  state_d = ST_DATA;
      ST_DATA:  state_d = we_q ? ST_WRITE : ST_IDLE;
      ST_WRITE: state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, request latch, memory-side registers and the response pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_lo_q   <= 2'b00;
      size_q      <= SZ_B;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      if (accept) begin
        addr_lo_q <= align_lo(req_size_e, bus.req_addr[1:0]);
        size_q    <= req_size_e;
        we_q      <= bus.req_we;
        uns_q     <= bus.req_unsigned;
        wdata_q   <= bus.req_wdata;
        if (illegal_req) begin
          // Error is answered straight away; the memory port is left alone.
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b1;
          rsp_rdata_q <= '0;
        end else begin
          mem_addr_q <= {bus.req_addr[ADDR_W-1:2], 2'b00};
          if (bus.req_we && (req_size_e == SZ_W)) mem_wdata_q <= bus.req_wdata;
        end
      end
      if (state_q == ST_DATA) begin
        if (we_q) begin
          mem_wdata_q <= merge_data;
        end else begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= load_data;
        end
      end
      if (state_q == ST_WRITE) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= '0;
      end
    end
  end

  lsu_lane_align u_lane (
    .addr_lo     (addr_lo_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .mem_word    (mem_rdata),
    .store_data  (wdata_q),
    .load_data   (load_data),
    .merge_data  (merge_data)
  );

  // Reset in the write cycle must not let the write through.
  assign mem_we        = (state_q == ST_WRITE) && !reset;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// Randomized scoreboard bench for lsu_rmw with directed corner cases.
module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];

  lsu_rmw_if #(.ADDR_W(32), .XLEN(32)) bus ();

  lsu_rmw #(.ADDR_W(32), .XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Word memory with registered read.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:2]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: byte-array view of the word, natural-size lanes.
  task automatic model(input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata, output exp_t e);
    int          nbytes, off;
    logic [31:0] word, mask, val;
    bit          bad;
    bad = (size == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    if (size == 2'b01 && addr[0]) bad = 1;
    if (size == 2'b10 && addr[1:0] != 2'b00) bad = 1;
`endif
    e.err = bad;
    e.rdata = 32'h0;
    e.lat = 1;
    e.cyc = 0;
    if (bad) return;
    nbytes = 1 << size;
    off = (int'(addr[1:0]) / nbytes) * nbytes;
    word = ref_mem[addr[7:2]];
    if (!we) begin
      mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
      val = (word >> (8 * off)) & mask;
      if (!uns && nbytes < 4 && val[8 * nbytes - 1]) val = val | ~mask;
      e.rdata = val;
      e.lat = 3;
    end else begin
      for (int i = 0; i < nbytes; i++) word[8 * (off + i) +: 8] = wdata[8 * i +: 8];
      ref_mem[addr[7:2]] = word;
      e.lat = (nbytes == 4) ? 2 : 4;
    end
  endtask

  // Present a request (called #1 after a posedge); returns the acceptance cycle.
  task automatic issue(input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input bit track, output int t);
    exp_t e;
    int   waited;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    t = -1;
    waited = 0;
    while (t < 0 && waited < 30) begin
      @(negedge clk);
      if (bus.req_ready) t = cyc;
      else waited++;
    end
    if (t < 0) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else if (track) begin
      model(we, size, uns, addr, wdata, e);
      e.cyc = t + e.lat;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sbq.size() != 0) check("drain_timeout", 32'(sbq.size()), 32'd0);
  endtask

  // Response monitor: pops the scoreboard whenever the DUT pulses rsp_valid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sbq.size() != 0 && sbq[0].cyc < cyc) begin
        e = sbq.pop_front();
        check("rsp_missing", 32'd0, 32'd1);
      end
      if (bus.rsp_valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          check("rsp_rdata", bus.rsp_rdata, e.rdata);
          check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          check("rsp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t, t1, t2, gap;
    bit          we, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata;

    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[16] = 32'h8899AABB;
    ref_mem[16] = 32'h8899AABB;

    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk);
    #1;

    issue(1'b0, 2'b00, 1'b0, 32'h43, 32'h0, 1'b1, t);  // LB  -> FFFFFF88
    issue(1'b0, 2'b00, 1'b1, 32'h43, 32'h0, 1'b1, t);  // LBU -> 00000088
    issue(1'b0, 2'b01, 1'b0, 32'h40, 32'h0, 1'b1, t);  // LH  -> FFFFAABB

    issue(1'b0, 2'b10, 1'b0, 32'h41, 32'h0, 1'b1, t);  // misaligned LW
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("lw41_no_write", 32'(mem_we), 32'd0);
    end
    @(posedge clk);
    #1;
    issue(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 1'b1, t);  // illegal size

    // Sub-word store aborted by reset in its write cycle.
    wait_drain();
    issue(1'b1, 2'b00, 1'b0, 32'h40, 32'h55, 1'b0, t);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_write_suppress", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_abort_ready", 32'(bus.req_ready), 32'd1);
    check("rst_abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1, t);  // still 8899AABB

    // SH 0x1234 at 0x42: single write of merged word at t+3.
    issue(1'b1, 2'b01, 1'b0, 32'h42, 32'h00001234, 1'b1, t);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("sh_mem_we", 32'(mem_we), (k == 3) ? 32'd1 : 32'd0);
      if (k <= 3) check("sh_mem_addr", mem_addr, 32'h40);
      if (k == 3) check("sh_mem_wdata", mem_wdata, 32'h1234AABB);
    end
    @(posedge clk);
    #1;
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1, t);

    // SW at 0x44: write in the first cycle after acceptance.
    issue(1'b1, 2'b10, 1'b0, 32'h44, 32'hDEADBEEF, 1'b1, t);
    @(negedge clk);
    check("sw_mem_we", 32'(mem_we), 32'd1);
    check("sw_mem_addr", mem_addr, 32'h44);
    check("sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    issue(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 1'b1, t);

    // Back-to-back loads with req_valid held high.
    wait_drain();
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1, t1);
    issue(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 1'b1, t2);
    check("b2b_accept_gap", 32'(t2 - t1), 32'd3);

    for (int n = 0; n < 150; n++) begin
      we    = 1'($urandom_range(0, 1));
      uns   = 1'($urandom_range(0, 1));
      size  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      addr  = 32'h40 + 32'($urandom_range(0, 63));
      wdata = $urandom;
      issue(we, size, uns, addr, wdata, 1'b1, t);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    wait_drain();
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
